// File: rtl/xgmii_ipg_shaper_32b.sv
//==============================================================================
// Module      : xgmii_ipg_shaper_32b
// Description : Store-and-forward XGMII 32-bit frame buffer. Frames are
//               re-emitted with a minimum average inter-packet gap, using a
//               deficit idle count. Malformed or oversize frames are dropped.
//               The output carries a periodic ena=0 slot for a gearbox PCS.
// Option      : define XGMII_SHAPER_DIC_EN to enable deficit idle count;
//               otherwise every gap is padded up to whole idle words.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package xgmii_ipg_shaper_32b_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic        ena;
  } xgmii32_t;
endpackage

module xgmii_ipg_shaper_32b
  import xgmii_ipg_shaper_32b_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int MIN_IPG    = 12,
  parameter int GAP_PERIOD = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  xgmii32_t    rx,
  output xgmii32_t    tx,
  output logic [15:0] drop_cnt,
  output logic        drop_pulse
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              EW         = 39;  // {p[1:0], term, ctrl[3:0], data[31:0]}
  localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
  localparam logic [31:0]     IDLE_DATA  = 32'h0707_0707;
  localparam logic [3:0]      IDLE_CTRL  = 4'hF;
  localparam logic [5:0]      MIN_IPG_W  = 6'(MIN_IPG);
  localparam logic [15:0]     PHASE_LAST = (GAP_PERIOD == 0) ? 16'd0 : 16'(GAP_PERIOD - 1);
`ifdef XGMII_SHAPER_DIC_EN
  localparam logic            DIC_ON     = 1'b1;
`else
  localparam logic            DIC_ON     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, fstart_q, commit_ptr_q, pend_ptr_q, rd_ptr_q;
  logic          open_q, pend_q;
  logic [15:0]   drop_cnt_q;
  logic          drop_pulse_q;

  // ---------------------------------------------------------------------------
  // Input word classification
  // ---------------------------------------------------------------------------
  logic       is_start, is_data, is_term, is_other;
  logic [1:0] term_p;

  // Decode the word class and, for terminates, the number of data bytes before T
  always_comb begin
    is_start = 1'b0;
    is_data  = 1'b0;
    is_term  = 1'b0;
    term_p   = 2'd0;
    if (rx.ena) begin
      case (rx.ctrl)
        4'b0001: is_start = (rx.data[7:0] == 8'hFB);
        4'b0000: is_data  = 1'b1;
        4'b1111: begin is_term = (rx.data[7:0]   == 8'hFD); term_p = 2'd0; end
        4'b1110: begin is_term = (rx.data[15:8]  == 8'hFD); term_p = 2'd1; end
        4'b1100: begin is_term = (rx.data[23:16] == 8'hFD); term_p = 2'd2; end
        4'b1000: begin is_term = (rx.data[31:24] == 8'hFD); term_p = 2'd3; end
        default: ;
      endcase
    end
  end

  assign is_other = rx.ena & ~is_start & ~is_data & ~is_term;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // A new START discards any open frame, so it always lands at the frame base.
  logic [AW-1:0] start_base, wr_addr;
  logic          start_full, wr_full, do_write, drop;
  logic [EW-1:0] wr_word;

  assign start_base = open_q ? fstart_q : wr_ptr_q;
  assign start_full = (start_base + PTR_ONE) == rd_ptr_q;
  assign wr_full    = (wr_ptr_q + PTR_ONE) == rd_ptr_q;
  assign wr_word    = {term_p, is_term, rx.ctrl, rx.data};

  // Decide whether this cycle writes a word and whether it discards a frame
  always_comb begin
    do_write = 1'b0;
    drop     = 1'b0;
    wr_addr  = wr_ptr_q;
    if (is_start) begin
      drop     = open_q | start_full;
      do_write = ~start_full;
      wr_addr  = start_base;
    end else if (open_q && (is_data || is_term)) begin
      drop     = wr_full;
      do_write = ~wr_full;
    end else if (open_q && is_other) begin
      drop     = 1'b1;
    end
  end

  // Frame buffer array write port
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  // Frame open/close, rewind on discard, delayed commit and drop counting
  always_ff @(posedge clk) begin
    if (rst) begin
      open_q       <= 1'b0;
      pend_q       <= 1'b0;
      wr_ptr_q     <= '0;
      fstart_q     <= '0;
      commit_ptr_q <= '0;
      pend_ptr_q   <= '0;
      drop_cnt_q   <= 16'd0;
      drop_pulse_q <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      if (pend_q) begin
        commit_ptr_q <= pend_ptr_q;
      end
      if (is_start) begin
        if (start_full) begin
          open_q   <= 1'b0;
          wr_ptr_q <= start_base;
        end else begin
          open_q   <= 1'b1;
          fstart_q <= start_base;
          wr_ptr_q <= start_base + PTR_ONE;
        end
      end else if (open_q && (is_data || is_term || is_other)) begin
        if (drop) begin
          open_q   <= 1'b0;
          wr_ptr_q <= fstart_q;
        end else begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
          if (is_term) begin
            open_q     <= 1'b0;
            pend_q     <= 1'b1;
            pend_ptr_q <= wr_ptr_q + PTR_ONE;
          end
        end
      end
      drop_pulse_q <= drop;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output enable pattern
  // ---------------------------------------------------------------------------
  logic [15:0] phase_q;
  logic        ena_now;

  assign ena_now = (GAP_PERIOD == 0) || (phase_q != PHASE_LAST);

  // Free-running phase counter that marks one disabled slot per period
  always_ff @(posedge clk) begin
    if (rst || (GAP_PERIOD == 0)) begin
      phase_q <= 16'd0;
    end else if (phase_q == PHASE_LAST) begin
      phase_q <= 16'd0;
    end else begin
      phase_q <= phase_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t        state_q;
  logic [1:0]    dic_q;
  logic [3:0]    gap_q;
  xgmii32_t      tx_q;

  logic [EW-1:0] rd_word;
  logic [1:0]    rd_p;
  logic          rd_term;
  logic [AW-1:0] rd_ptr_inc;
  logic          avail_now, avail_after;

  assign rd_word     = mem_q[rd_ptr_q];
  assign rd_p        = rd_word[38:37];
  assign rd_term     = rd_word[36];
  assign rd_ptr_inc  = rd_ptr_q + PTR_ONE;
  // Commits always cover whole frames, so any unread committed word means a frame.
  assign avail_now   = commit_ptr_q != rd_ptr_q;
  assign avail_after = commit_ptr_q != rd_ptr_inc;

  logic [2:0] g0;
  logic [3:0] gap_n, gap_words;
  logic [1:0] gap_e, dic_d;
  logic [2:0] dic_sum;
  logic       use_short;

  // Idle-word count after a terminate: T-word bytes g0, whole-word padding n,
  // excess e, and the optional one-word shortening paid for by the deficit
  always_comb begin
    g0        = 3'd4 - {1'b0, rd_p};
    gap_n     = 4'((MIN_IPG_W - {3'd0, g0} + 6'd3) >> 2);
    gap_e     = 2'({3'd0, g0} + {gap_n, 2'b00} - MIN_IPG_W);
    dic_sum   = {1'b0, dic_q} + (3'd4 - {1'b0, gap_e});
    use_short = DIC_ON && (dic_sum <= 3'd3);
    if (use_short) begin
      gap_words = gap_n - 4'd1;
      dic_d     = dic_sum[1:0];
    end else begin
      gap_words = gap_n;
      dic_d     = (dic_q > gap_e) ? (dic_q - gap_e) : 2'd0;
    end
    if (!DIC_ON) begin
      dic_d = 2'd0;
    end
  end

  // Read FSM with registered output; ena=0 slots emit idle and freeze everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      dic_q     <= 2'd0;
      gap_q     <= 4'd0;
      tx_q.data <= IDLE_DATA;
      tx_q.ctrl <= IDLE_CTRL;
      tx_q.ena  <= 1'b0;
    end else begin
      tx_q.data <= IDLE_DATA;
      tx_q.ctrl <= IDLE_CTRL;
      tx_q.ena  <= ena_now;
      if (ena_now) begin
        case (state_q)
          ST_IDLE: begin
            if (avail_now) begin
              state_q <= ST_SEND;
            end
          end
          ST_SEND: begin
            tx_q.data <= rd_word[31:0];
            tx_q.ctrl <= rd_word[35:32];
            rd_ptr_q  <= rd_ptr_inc;
            if (rd_term) begin
              dic_q <= dic_d;
              if (gap_words == 4'd0) begin
                state_q <= avail_after ? ST_SEND : ST_IDLE;
              end else begin
                gap_q   <= gap_words;
                state_q <= ST_GAP;
              end
            end
          end
          ST_GAP: begin
            gap_q <= gap_q - 4'd1;
            if (gap_q <= 4'd1) begin
              state_q <= avail_now ? ST_SEND : ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign drop_cnt   = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_xgmii_ipg_shaper_32b.sv
//==============================================================================
// Module      : tb_xgmii_ipg_shaper_32b
// Description : Directed self-checking bench for xgmii_ipg_shaper_32b. Three
//               instances cover the gap/DIC behaviour, the small-buffer drop
//               cases and the periodic ena pattern. One instance is driven
//               at a time; the monitor watches the selected one.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_xgmii_ipg_shaper_32b;
  import xgmii_ipg_shaper_32b_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  xgmii32_t    rx  = '0;
  xgmii32_t    rx_a, rx_b, rx_c, tx_a, tx_b, tx_c, tx_m;
  logic [15:0] dc_a, dc_b, dc_c, dc_m;
  logic        dp_a, dp_b, dp_c, dp_m;

  always #5 clk = ~clk;

  assign rx_a = (sel == 0) ? rx : '0;
  assign rx_b = (sel == 1) ? rx : '0;
  assign rx_c = (sel == 2) ? rx : '0;
  assign tx_m = (sel == 0) ? tx_a : (sel == 1) ? tx_b : tx_c;
  assign dc_m = (sel == 0) ? dc_a : (sel == 1) ? dc_b : dc_c;
  assign dp_m = (sel == 0) ? dp_a : (sel == 1) ? dp_b : dp_c;

  xgmii_ipg_shaper_32b #(.DEPTH(512), .MIN_IPG(12), .GAP_PERIOD(0)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .drop_cnt(dc_a), .drop_pulse(dp_a));
  xgmii_ipg_shaper_32b #(.DEPTH(16), .MIN_IPG(12), .GAP_PERIOD(0)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .drop_cnt(dc_b), .drop_pulse(dp_b));
  xgmii_ipg_shaper_32b #(.DEPTH(512), .MIN_IPG(12), .GAP_PERIOD(33)) dut_c (
    .clk(clk), .rst(rst), .rx(rx_c), .tx(tx_c), .drop_cnt(dc_c), .drop_pulse(dp_c));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and output monitor
  int          cyc = 0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  int          gap_q[$];
  int          start_cyc[$];
  int          ena0_cyc[$];
  int          pulse_cnt = 0;
  int          ena0_busy = 0;
  int          idle_run  = 0;
  bit          have_term = 0;
  int          first_term_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_m) pulse_cnt++;
      if (!tx_m.ena) begin
        ena0_cyc.push_back(cyc);
        if (!(tx_m.ctrl == 4'hF && tx_m.data == 32'h07070707)) ena0_busy++;
      end else if (tx_m.ctrl == 4'hF && tx_m.data == 32'h07070707) begin
        if (have_term) idle_run++;
      end else begin
        got_q.push_back({tx_m.ctrl, tx_m.data});
        if (tx_m.ctrl == 4'b0001) begin
          start_cyc.push_back(cyc);
          if (have_term) gap_q.push_back(idle_run);
          have_term = 0;
        end
        if (tx_m.ctrl[3]) begin
          have_term = 1;
          idle_run  = 0;
        end
      end
    end
  end

  function automatic xgmii32_t mk_start();
    xgmii32_t w;
    w.data = 32'hD55555FB; w.ctrl = 4'b0001; w.ena = 1'b1;
    return w;
  endfunction

  function automatic xgmii32_t mk_data(input int id, input int i);
    xgmii32_t w;
    w.data = {8'(id), 8'hA0, 8'(i), 8'h5A}; w.ctrl = 4'b0000; w.ena = 1'b1;
    return w;
  endfunction

  function automatic xgmii32_t mk_term(input int p);
    xgmii32_t w;
    w.ena = 1'b1;
    case (p)
      0:       begin w.data = 32'h070707FD; w.ctrl = 4'b1111; end
      1:       begin w.data = 32'h0707FDE1; w.ctrl = 4'b1110; end
      2:       begin w.data = 32'h07FDE2E1; w.ctrl = 4'b1100; end
      default: begin w.data = 32'hFDE3E2E1; w.ctrl = 4'b1000; end
    endcase
    return w;
  endfunction

  task automatic drive(input xgmii32_t w, input bit keep);
    rx = w;
    if (keep) exp_q.push_back({w.ctrl, w.data});
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int len, input int p, input int id, input bit keep);
    drive(mk_start(), keep);
    for (int i = 1; i < len - 1; i++) drive(mk_data(id, i), keep);
    if (first_term_cyc < 0) first_term_cyc = cyc;
    drive(mk_term(p), keep);
    rx = '0;
  endtask

  task automatic do_reset(input int s, input string tag);
    rx  = '0;
    rst = 1'b1;
    sel = s;
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_rst_data"}, 64'(tx_m.data), 64'h07070707);
    check_val({tag, "_rst_ctrl"}, 64'(tx_m.ctrl), 64'hF);
    check_val({tag, "_rst_ena"},  64'(tx_m.ena),  64'h0);
    check_val({tag, "_rst_dcnt"}, 64'(dc_m),      64'h0);
    check_val({tag, "_rst_dpul"}, 64'(dp_m),      64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete(); gap_q.delete(); start_cyc.delete(); ena0_cyc.delete();
    pulse_cnt = 0; ena0_busy = 0; idle_run = 0; have_term = 0; first_term_cyc = -1;
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (got_q.size() < exp_q.size() && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_words(input string tag);
    check_val({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_val($sformatf("%s_w%0d", tag, i),
                (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'(exp_q[i]));
    end
  endtask

  // Hand-derived idle-word counts for the repeating p=1 stream (MIN_IPG=12)
`ifdef XGMII_SHAPER_DIC_EN
  int exp_p1[8] = '{2, 2, 2, 3, 2, 2, 2, 3};
`else
  int exp_p1[8] = '{3, 3, 3, 3, 3, 3, 3, 3};
`endif

  initial begin
    // Back-to-back p=0 frames: 2 idle words every gap, latency 4 from idle
    do_reset(0, "a0");
    for (int f = 0; f < 9; f++) send_frame(6, 0, f, 1'b1);
    wait_drain(400);
    check_words("a0");
    check_val("a0_latency", (start_cyc.size() > 0) ? 64'(start_cyc[0] - first_term_cyc) : 64'hFFFF, 64'd4);
    check_val("a0_ngaps", 64'(gap_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("a0_gap%0d", i), (i < gap_q.size()) ? 64'(gap_q[i]) : 64'hFF, 64'd2);

    // Repeating p=1 frames: gap pattern depends on deficit idle count
    do_reset(0, "a1");
    for (int f = 0; f < 9; f++) send_frame(6, 1, f + 16, 1'b1);
    wait_drain(400);
    check_words("a1");
    check_val("a1_ngaps", 64'(gap_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("a1_gap%0d", i), (i < gap_q.size()) ? 64'(gap_q[i]) : 64'hFF, 64'(exp_p1[i]));
    check_val("a1_dcnt", 64'(dc_m), 64'd0);

    // DEPTH=16: latency, oversize drop, then an intact 4-word frame
    do_reset(1, "b0");
    send_frame(4, 3, 40, 1'b1);
    wait_drain(100);
    check_val("b0_latency", (start_cyc.size() > 0) ? 64'(start_cyc[0] - first_term_cyc) : 64'hFFFF, 64'd4);
    send_frame(16, 0, 41, 1'b0);
    send_frame(4, 2, 42, 1'b1);
    wait_drain(100);
    check_words("b0");
    check_val("b0_dcnt",   64'(dc_m),      64'd1);
    check_val("b0_pulses", 64'(pulse_cnt), 64'd1);

    // START, DATA, START, DATA, TERM: first frame dropped, second kept
    do_reset(1, "b1");
    drive(mk_start(), 1'b0);
    drive(mk_data(50, 1), 1'b0);
    drive(mk_start(), 1'b1);
    drive(mk_data(51, 1), 1'b1);
    drive(mk_term(1), 1'b1);
    rx = '0;
    wait_drain(100);
    check_words("b1");
    check_val("b1_dcnt",   64'(dc_m),      64'd1);
    check_val("b1_pulses", 64'(pulse_cnt), 64'd1);

    // GAP_PERIOD=33 under continuous traffic
    do_reset(2, "c0");
    for (int f = 0; f < 20; f++) send_frame(6, 0, f + 64, 1'b1);
    wait_drain(600);
    check_words("c0");
    check_val("c0_ena0_seen", 64'(ena0_cyc.size() >= 4), 64'd1);
    begin
      int bad_iv = 0;
      for (int i = 1; i < ena0_cyc.size(); i++)
        if (ena0_cyc[i] - ena0_cyc[i-1] != 33) bad_iv++;
      check_val("c0_ena0_period", 64'(bad_iv), 64'd0);
    end
    check_val("c0_ena0_idle", 64'(ena0_busy), 64'd0);
    check_val("c0_dcnt", 64'(dc_m), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
